// File: rtl/regfile_pkg.sv
// regfile_pkg -- definitions shared by the register file and its write controller.
//   NREGS      : number of architectural registers
//   REG_IDX_W  : width of a register index
//   rf_state_e : write-controller FSM states (INIT = zero-fill, RUN = normal writes)
package regfile_pkg;
   localparam int NREGS     = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_e;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // True for the highest register index, i.e. the last zero-fill step.
   function automatic logic is_last_reg(input reg_idx_t idx);
      return idx == reg_idx_t'(NREGS - 1);
   endfunction
endpackage

// File: rtl/regfile_wr_ctrl_rr_arb2.sv
// rr_arb2 -- two-input round-robin arbiter with a registered last-grant pointer.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   en_i               : grants allowed this cycle
//   req_a_i, req_b_i   : requests
//   gnt_a_o, gnt_b_o   : one-hot (or zero) grants, combinational from requests
// A grant is only issued to a requester that is requesting, so every grant is
// an accepted transfer and the pointer moves on each grant.
module rr_arb2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic req_a_i,
   input  logic req_b_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);
   // prio_b_q = 1 : B is favoured on a tie (A was granted last)
   logic prio_b_q, prio_b_d;

   always_comb begin
      gnt_a_o  = en_i & req_a_i & (~req_b_i | ~prio_b_q);
      gnt_b_o  = en_i & req_b_i & (~req_a_i |  prio_b_q);
      prio_b_d = prio_b_q;
      if (gnt_a_o)      prio_b_d = 1'b1;
      else if (gnt_b_o) prio_b_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) prio_b_q <= 1'b0;
      else       prio_b_q <= prio_b_d;
   end
endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl -- merges two write requesters (A: ALU writeback, B: load
// unit) onto the single register-file write port, after an optional zero-fill.
//   HCLK, HRESET              : clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data : requester A handshake, index, data
//   b_valid/b_ready/b_rd/b_data : requester B handshake, index, data
//   WR, RW, DW                : register-file write enable / index / data
//   init_done                 : zero-fill finished (or skipped)
//   gnt_b                     : source of the write on WR/RW/DW (0 = A, 1 = B)
// Accepted writes come out one cycle after acceptance. During zero-fill the
// port is driven straight from the counter so RW runs 0..31 over the 32 INIT
// cycles.
module regfile_wr_ctrl
   import regfile_pkg::*;
#(
   parameter int unsigned INIT_EN = 1,
   parameter int unsigned XLEN    = 32
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [REG_IDX_W-1:0] a_rd,
   input  logic [XLEN-1:0]      a_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [REG_IDX_W-1:0] b_rd,
   input  logic [XLEN-1:0]      b_data,
   output logic                 WR,
   output logic [REG_IDX_W-1:0] RW,
   output logic [XLEN-1:0]      DW,
   output logic                 init_done,
   output logic                 gnt_b
);
   localparam rf_state_e RST_STATE = (INIT_EN != 0) ? INIT : RUN;

   rf_state_e       state_q, state_d;
   reg_idx_t        cnt_q,   cnt_d;
   logic            wr_q,    wr_d;
   reg_idx_t        rw_q,    rw_d;
   logic [XLEN-1:0] dw_q,    dw_d;
   logic            gnt_b_q, gnt_b_d;

   logic in_init, arb_en, arb_gnt_a, arb_gnt_b;

   assign in_init = (state_q == INIT);
   // Readies are cut by HRESET directly so nothing is accepted while in reset.
   assign arb_en  = (state_q == RUN) & ~HRESET;

   rr_arb2 u_arb (
      .clk_i   (HCLK),
      .rst_i   (HRESET),
      .en_i    (arb_en),
      .req_a_i (a_valid),
      .req_b_i (b_valid),
      .gnt_a_o (arb_gnt_a),
      .gnt_b_o (arb_gnt_b)
   );

   assign a_ready = arb_gnt_a;
   assign b_ready = arb_gnt_b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = 1'b0;
      rw_d    = rw_q;
      dw_d    = dw_q;
      gnt_b_d = gnt_b_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            // Track the fill index so RW holds the last written index once in RUN.
            rw_d  = cnt_q;
            dw_d  = '0;
            if (is_last_reg(cnt_q)) state_d = RUN;
         end
         RUN: begin
            // x0 writes complete the handshake but never assert WR.
            if (arb_gnt_a) begin
               wr_d    = (a_rd != '0);
               rw_d    = a_rd;
               dw_d    = a_data;
               gnt_b_d = 1'b0;
            end else if (arb_gnt_b) begin
               wr_d    = (b_rd != '0);
               rw_d    = b_rd;
               dw_d    = b_data;
               gnt_b_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         rw_q    <= '0;
         dw_q    <= '0;
         gnt_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rw_q    <= rw_d;
         dw_q    <= dw_d;
         gnt_b_q <= gnt_b_d;
      end
   end

   // Zero-fill drives the port from the counter in the same cycle; WR is held
   // low while HRESET is asserted so the reset values are what is seen.
   assign WR        = in_init ? ~HRESET : wr_q;
   assign RW        = in_init ? cnt_q   : rw_q;
   assign DW        = in_init ? '0      : dw_q;
   assign gnt_b     = gnt_b_q;
   assign init_done = (state_q == RUN) & ~HRESET;
endmodule

// File: tb/tb_regfile_wr_ctrl.sv
module tb_regfile_wr_ctrl;
   localparam logic [31:0] BD = 32'hFFFB6BC2;
   localparam logic [31:0] XD = 32'h80700383;

   logic        HCLK, HRESET;
   logic        a_valid, b_valid;
   logic [4:0]  a_rd, b_rd;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready, WR, init_done, gnt_b;
   logic [4:0]  RW;
   logic [31:0] DW;
   logic        d0_a_ready, d0_b_ready, d0_WR, d0_init_done, d0_gnt_b;
   logic [4:0]  d0_RW;
   logic [31:0] d0_DW;

   regfile_wr_ctrl #(.INIT_EN(1), .XLEN(32)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .WR(WR), .RW(RW), .DW(DW), .init_done(init_done), .gnt_b(gnt_b)
   );

   regfile_wr_ctrl #(.INIT_EN(0), .XLEN(32)) dut0 (
      .HCLK(HCLK), .HRESET(HRESET),
      .a_valid(a_valid), .a_ready(d0_a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(d0_b_ready), .b_rd(b_rd), .b_data(b_data),
      .WR(d0_WR), .RW(d0_RW), .DW(d0_DW), .init_done(d0_init_done), .gnt_b(d0_gnt_b)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: zero-fill progress, tie-break preference and the write
   // that should be visible on the port in the coming cycle.
   int          m_init;
   bit          m_fav_b, m_rst_seen, m_prev_rst, m_known, m_acc_a, m_acc_b;
   logic        m_wr, m_g;
   logic [4:0]  m_rw;
   logic [31:0] m_dw;

   task automatic drive_cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                              input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
                              input logic rst);
      int who;
      @(negedge HCLK);
      HRESET = rst; a_valid = av; a_rd = ard; a_data = adat;
      b_valid = bv; b_rd = brd; b_data = bdat;
      #1;
      m_acc_a = 0; m_acc_b = 0;
      check("one_ready", 32'(a_ready & b_ready), 32'd0);
      if (rst) begin
         check("rst_a_ready", 32'(a_ready), 32'd0);
         check("rst_b_ready", 32'(b_ready), 32'd0);
         check("rst_init_done", 32'(init_done), 32'd0);
         if (m_rst_seen) check("rst_d0_init_done", 32'(d0_init_done), 32'd0);
         if (m_prev_rst) begin
            check("rst_WR", 32'(WR), 32'd0);
            check("rst_RW", 32'(RW), 32'd0);
            check("rst_DW", DW, 32'd0);
            check("rst_gnt_b", 32'(gnt_b), 32'd0);
         end
         m_rst_seen = 1; m_init = 0; m_fav_b = 0; m_known = 1;
         m_wr = 0; m_rw = 0; m_dw = 0; m_g = 0;
      end else if (m_init < 32) begin
         check("init_a_ready", 32'(a_ready), 32'd0);
         check("init_b_ready", 32'(b_ready), 32'd0);
         check("init_WR", 32'(WR), 32'd1);
         check("init_RW", 32'(RW), 32'(m_init));
         check("init_DW", DW, 32'd0);
         check("init_done_lo", 32'(init_done), 32'd0);
         m_init++;
         if (m_init == 32) begin m_wr = 0; m_rw = 5'd31; m_dw = 0; end
      end else begin
         who = -1;
         if (av && bv) who = m_fav_b ? 1 : 0;
         else if (av)  who = 0;
         else if (bv)  who = 1;
         check("run_a_ready", 32'(a_ready), 32'(who == 0));
         check("run_b_ready", 32'(b_ready), 32'(who == 1));
         check("run_WR", 32'(WR), 32'(m_wr));
         if (m_known) begin
            check("run_RW", 32'(RW), 32'(m_rw));
            check("run_DW", DW, m_dw);
         end
         check("run_gnt_b", 32'(gnt_b), 32'(m_g));
         check("run_init_done", 32'(init_done), 32'd1);
         if (who >= 0) begin
            m_rw    = (who == 0) ? ard : brd;
            m_dw    = (who == 0) ? adat : bdat;
            m_wr    = (m_rw != 0);
            m_known = (m_rw != 0);
            m_g     = (who == 1);
            m_fav_b = (who == 0);
            m_acc_a = (who == 0);
            m_acc_b = (who == 1);
         end else begin
            m_wr = 0;
         end
      end
      if (!rst && m_rst_seen) check("d0_init_done", 32'(d0_init_done), 32'd1);
      m_prev_rst = rst;
   endtask

   task automatic idle(input logic rst);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rst);
   endtask

   typedef struct {
      logic av; logic [4:0] ard; logic [31:0] adat;
      logic bv; logic [4:0] brd; logic [31:0] bdat;
      logic ea; logic eb;
      logic ewr; logic [4:0] erw; logic [31:0] edw; logic eg;
      logic chk;
   } vec_t;

   vec_t tbl[23];

   initial begin
      logic        pav, pbv;
      logic [4:0]  par, pbr;
      logic [31:0] pad, pbd;
      int          n;
      bit          ok;

      HRESET = 1'b1; a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
      m_init = 0; m_fav_b = 0; m_rst_seen = 0; m_prev_rst = 0; m_known = 1;
      m_acc_a = 0; m_acc_b = 0; m_wr = 0; m_g = 0; m_rw = 0; m_dw = 0;

      // Contention, single write, idle, x0 and same-index rows, run straight after zero-fill.
      tbl[0]  = '{1'b1,5'd10,32'd200,1'b1,5'd20,BD, 1'b1,1'b0, 1'b0,5'd31,32'd0,1'b0, 1'b1};
      tbl[1]  = '{1'b1,5'd10,32'd200,1'b1,5'd20,BD, 1'b0,1'b1, 1'b1,5'd10,32'd200,1'b0, 1'b1};
      tbl[2]  = '{1'b1,5'd10,32'd200,1'b1,5'd20,BD, 1'b1,1'b0, 1'b1,5'd20,BD,1'b1, 1'b1};
      tbl[3]  = '{1'b0,5'd10,32'd200,1'b1,5'd20,BD, 1'b0,1'b1, 1'b1,5'd10,32'd200,1'b0, 1'b1};
      tbl[4]  = '{1'b0,5'd0,32'd0,1'b0,5'd0,32'd0,  1'b0,1'b0, 1'b1,5'd20,BD,1'b1, 1'b1};
      tbl[5]  = '{1'b1,5'd5,32'd100,1'b0,5'd0,32'd0, 1'b1,1'b0, 1'b0,5'd20,BD,1'b1, 1'b1};
      tbl[6]  = '{1'b0,5'd0,32'd0,1'b0,5'd0,32'd0,  1'b0,1'b0, 1'b1,5'd5,32'd100,1'b0, 1'b1};
      for (int i = 7; i < 17; i++)
         tbl[i] = '{1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,1'b0, 1'b0,5'd5,32'd100,1'b0, 1'b1};
      tbl[17] = '{1'b0,5'd0,32'd0,1'b1,5'd0,XD,     1'b0,1'b1, 1'b0,5'd5,32'd100,1'b0, 1'b1};
      tbl[18] = '{1'b0,5'd0,32'd0,1'b0,5'd0,32'd0,  1'b0,1'b0, 1'b0,5'd0,32'd0,1'b1, 1'b0};
      tbl[19] = '{1'b1,5'd7,32'd1,1'b1,5'd7,32'd2,  1'b1,1'b0, 1'b0,5'd0,32'd0,1'b1, 1'b0};
      tbl[20] = '{1'b0,5'd7,32'd1,1'b1,5'd7,32'd2,  1'b0,1'b1, 1'b1,5'd7,32'd1,1'b0, 1'b1};
      tbl[21] = '{1'b0,5'd0,32'd0,1'b0,5'd0,32'd0,  1'b0,1'b0, 1'b1,5'd7,32'd2,1'b1, 1'b1};
      tbl[22] = '{1'b0,5'd0,32'd0,1'b0,5'd0,32'd0,  1'b0,1'b0, 1'b0,5'd7,32'd2,1'b1, 1'b1};

      // Reset and zero-fill with both requesters pushing the whole time.
      for (int i = 0; i < 3; i++) drive_cycle(1'b1,5'd10,32'd200,1'b1,5'd20,BD,1'b1);
      for (int i = 0; i < 32; i++) drive_cycle(1'b1,5'd10,32'd200,1'b1,5'd20,BD,1'b0);

      for (int i = 0; i < 23; i++) begin
         drive_cycle(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].bv, tbl[i].brd, tbl[i].bdat, 1'b0);
         check($sformatf("tbl%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ea));
         check($sformatf("tbl%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].eb));
         check($sformatf("tbl%0d_WR", i), 32'(WR), 32'(tbl[i].ewr));
         check($sformatf("tbl%0d_gnt_b", i), 32'(gnt_b), 32'(tbl[i].eg));
         if (tbl[i].chk) begin
            check($sformatf("tbl%0d_RW", i), 32'(RW), 32'(tbl[i].erw));
            check($sformatf("tbl%0d_DW", i), DW, tbl[i].edw);
         end
      end

      // Reset once RW has reached 12 during zero-fill; the fill must restart at 0.
      idle(1'b1); idle(1'b1);
      for (int i = 0; i < 13; i++) idle(1'b0);
      check("midinit_RW12", 32'(RW), 32'd12);
      idle(1'b1); idle(1'b1);
      n = 0; ok = 1;
      for (int k = 0; k < 100; k++) begin
         idle(1'b0);
         if (init_done === 1'b1) break;
         if (WR !== 1'b1 || RW !== 5'(n)) ok = 0;
         n++;
      end
      check("reinit_len", 32'(n), 32'd32);
      check("reinit_seq", 32'(ok), 32'd1);

      // Randomized traffic; a requester holds its request until accepted.
      pav = 0; pbv = 0; par = 0; pbr = 0; pad = 0; pbd = 0;
      for (int c = 0; c < 600; c++) begin
         if (!pav && $urandom_range(0, 99) < 60) begin
            pav = 1; par = 5'($urandom_range(0, 31)); pad = $urandom;
         end
         if (!pbv && $urandom_range(0, 99) < 60) begin
            pbv = 1; pbr = 5'($urandom_range(0, 31)); pbd = $urandom;
         end
         drive_cycle(pav, par, pad, pbv, pbr, pbd, 1'($urandom_range(0, 299) == 0));
         if (m_acc_a) pav = 0;
         if (m_acc_b) pbv = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_wr_ctrl.md
REGFILE_WR_CTRL -- requirements
Module: regfile_wr_ctrl

Interface
REQ-001 Parameter INIT_EN, default 1, meaning: 1 = zero-fill all 32 registers after reset; 0 = skip to RUN.
REQ-002 Parameter XLEN, default 32, meaning: data width of the write port.
REQ-003 HCLK  in  1  clock; the single clock, all state updates on its rising edge.
REQ-004 HRESET  in  1  reset; synchronous and active-high.
REQ-005 a_valid  in  1  requester A (ALU writeback) has a write pending.
REQ-006 a_ready  out  1  requester A write accepted this cycle.
REQ-007 a_rd  in  5  requester A destination register index.
REQ-008 a_data  in  XLEN  requester A write data.
REQ-009 b_valid, b_ready, b_rd, b_data  in/out/in/in  1/1/5/XLEN  requester B (load unit); same meanings as A.
REQ-010 WR  out  1  register-file write enable.
REQ-011 RW  out  5  register-file write index.
REQ-012 DW  out  XLEN  register-file write data.
REQ-013 init_done  out  1  high once zero-fill is complete; stays high until the next reset.
REQ-014 gnt_b  out  1  registered; identifies the requester whose write is on WR/RW/DW (0 = A, 1 = B).

Function
REQ-015 FSM states: INIT, RUN; INIT is entered from reset when INIT_EN=1, RUN when INIT_EN=0.
REQ-016 INIT: 5-bit counter from 0; each cycle WR=1, RW=counter, DW=0, and the counter increments.
REQ-017 INIT: a_ready=b_ready=0 regardless of valid.
REQ-018 INIT lasts exactly 32 cycles (RW 0..31); after the RW=31 cycle the FSM moves to RUN and init_done goes to 1.
REQ-019 RUN: a requester is accepted when ready and valid are both high in the same cycle; ready SHALL NOT depend on ready from any other block.
REQ-020 RUN, one valid: that requester gets ready=1.
REQ-021 RUN, both valid: round-robin; the requester not granted most recently gets ready=1 and the other gets 0.
REQ-022 After reset the round-robin pointer favours A.
REQ-023 The round-robin pointer updates only on an accepted transfer.
REQ-024 At most one ready is high per cycle.
REQ-025 Latency: an accepted write appears on WR/RW/DW/gnt_b in the cycle after acceptance, held for exactly one cycle.
REQ-026 Back-to-back acceptances are allowed every cycle; throughput is 1 write per cycle.
REQ-027 An accepted write with rd=0 completes the handshake, but WR=0 in its output cycle (x0 is never written in RUN).
REQ-028 Same rd from both requesters in one cycle: only the granted one is written that cycle; the other is held off by ready=0 and is written in a later cycle.
REQ-029 No accept cycle: WR=0; RW and DW hold their previous values.
REQ-030 A requester that is not granted SHALL keep valid, rd and data stable; the block does not buffer requests.

Reset
REQ-031 When HRESET=1 at a clock edge, all of the following reset:
- WR=0, RW=0, DW=0, gnt_b=0
- init_done=0, INIT counter=0, round-robin pointer favours A
- state=INIT if INIT_EN=1, else RUN
REQ-032 While HRESET=1, a_ready=b_ready=0.
REQ-033 Reset asserted mid-INIT restarts zero-fill at RW=0.
REQ-034 Reset asserted during RUN drops any write not yet driven on WR without completing it.
REQ-035 When INIT_EN=0, init_done=1 from the first cycle after reset release.

Structure
REQ-036 A shared package regfile_pkg holds the following; both this block and the register file use them:
- constants NREGS=32 and REG_IDX_W=5
- the FSM state enum {INIT, RUN}
REQ-037 One sub-module, rr_arb2: a 2-input round-robin arbiter with registered last-grant pointer; the FSM, INIT counter and output registers stay in regfile_wr_ctrl.

Verification
REQ-038 Zero-fill:
- stimulus: reset, INIT_EN=1, both valid held high
- response: 32 cycles of WR=1, RW=0..31, DW=0, no ready; then init_done=1 and the first grant goes to A
REQ-039 Single requester:
- stimulus: in RUN, a_valid=1, a_rd=5, a_data=100
- response: a_ready=1; next cycle WR=1, RW=5, DW=100, gnt_b=0
REQ-040 Contention:
- stimulus: both valid for 4 cycles; A rd=10 data=200, B rd=20 data=0xFFFB6BC2; each requester drops valid after its second accept
- response: grants A,B,A,B; WR sequence (10,200),(20,0xFFFB6BC2),(10,200),(20,0xFFFB6BC2)
REQ-041 x0 suppression:
- stimulus: b_valid=1, b_rd=0, b_data=0x80700383
- response: b_ready=1; next cycle WR=0
REQ-042 Reset mid-INIT:
- stimulus: assert HRESET after RW reaches 12
- response: zero-fill restarts at RW=0 and runs a full 32 cycles before init_done=1
REQ-043 Idle:
- stimulus: no valid for 10 cycles in RUN
- response: WR=0 throughout, both ready=0, RW/DW unchanged
